store_buffer: RTL and testbench

- Posted-write buffer between the CPU MEM stage and DataMemory.
- Accepts stores in one cycle and drains them into DataMemory in the background, one per cycle.
- Services loads either by forwarding from buffered stores or by a direct DataMemory read.
- Removes store stalls from the pipeline while keeping load results coherent with program order.

---
 rtl/cpu16_mem_pkg.sv | 16 +
 rtl/store_buffer_match.sv | 39 +++
 rtl/store_buffer.sv | 134 +++++++++++++
 tb/tb_store_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_mem_pkg.sv
// Shared widths, defaults and entry layout for the CPU16 data-memory path.
// A buffered store entry is packed as {addr, data}: address in the upper AW bits.
package cpu16_mem_pkg;

    localparam int MEM_AW   = 16;
    localparam int MEM_DW   = 16;
    localparam int SB_DEPTH = 4;
    localparam int ENTRY_W  = MEM_AW + MEM_DW;

    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_DRAIN = 2'd1,
        PORT_LOAD  = 2'd2
    } port_op_e;

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-match search over the buffered stores for a load address.
// Scans from the newest entry (tail-1) back towards head; the first valid match wins.
module store_buffer_match #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic [AW+DW-1:0]          entries_i [DEPTH],
    input  logic [DEPTH-1:0]          valid_i,
    input  logic [$clog2(DEPTH)-1:0]  head_i,
    input  logic [$clog2(DEPTH)-1:0]  tail_i,
    input  logic [AW-1:0]             addr_i,
    output logic                      hit_o,
    output logic [DW-1:0]             data_o
);

    localparam int PW = $clog2(DEPTH);

    always_comb begin
        logic [PW-1:0] idx;
        logic          stop;
        hit_o  = 1'b0;
        data_o = '0;
        stop   = 1'b0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail_i - PW'(k + 1);
            if (!stop && !hit_o && valid_i[idx] &&
                entries_i[idx][AW+DW-1:DW] == addr_i) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx][DW-1:0];
            end
            // head is the oldest entry; nothing older can be live.
            if (idx == head_i)
                stop = 1'b1;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the CPU MEM stage and DataMemory: single-cycle store
// accept, background drain one entry per cycle, load forwarding from buffered stores.
module store_buffer
    import cpu16_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          StReq,
    input  logic          LdReq,
    input  logic [AW-1:0] CpuAdresa,
    input  logic [DW-1:0] CpuWriteData,
    output logic [DW-1:0] CpuReadData,
    output logic          CpuReady,
    output logic          Full,
    output logic          Empty,
    output logic [AW-1:0] Adresa,
    output logic [DW-1:0] WriteData,
    output logic          MemWrite,
    output logic          MemRead,
    input  logic [DW-1:0] ReadData
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW+DW-1:0] entry_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DW-1:0]    rdata_q, rdata_d;

    logic [DEPTH-1:0] valid;
    logic             hit;
    logic [DW-1:0]    hit_data;
    logic             ld_miss;
    logic             ld_svc;
    logic             push;
    logic             pop;
    port_op_e         port_op;

    always_comb begin
        logic [PW-1:0] age;
        age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age      = PW'(i) - head_q;
            valid[i] = {1'b0, age} < count_q;
        end
    end

    store_buffer_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_match (
        .entries_i (entry_q),
        .valid_i   (valid),
        .head_i    (head_q),
        .tail_i    (tail_q),
        .addr_i    (CpuAdresa),
        .hit_o     (hit),
        .data_o    (hit_data)
    );

    // A presented load that misses reserves the memory port even when a
    // simultaneous store wins the CPU side, so draining pauses until it is served.
    always_comb begin
        ld_miss = Reset && LdReq && !hit;
        ld_svc  = Reset && LdReq && !StReq;
        if (ld_miss)
            port_op = StReq ? PORT_IDLE : PORT_LOAD;
        else if (count_q != '0)
            port_op = PORT_DRAIN;
        else
            port_op = PORT_IDLE;
    end

    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Adresa    = '0;
        WriteData = '0;
        case (port_op)
            PORT_LOAD: begin
                MemRead = 1'b1;
                Adresa  = CpuAdresa;
            end
            PORT_DRAIN: begin
                MemWrite  = 1'b1;
                Adresa    = entry_q[head_q][AW+DW-1:DW];
                WriteData = entry_q[head_q][DW-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        pop      = (port_op == PORT_DRAIN);
        push     = Reset && StReq && ((count_q != CW'(DEPTH)) || pop);
        CpuReady = StReq ? push : ld_svc;
        rdata_d  = rdata_q;
        if (ld_svc)
            rdata_d = hit ? hit_data : ReadData;
        CpuReadData = rdata_d;
        head_d   = pop  ? head_q + 1'b1 : head_q;
        tail_d   = push ? tail_q + 1'b1 : tail_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        Full     = (count_q == CW'(DEPTH));
        Empty    = (count_q == '0);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (push)
            entry_q[tail_q] <= {CpuAdresa, CpuWriteData};
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a combinational-read DataMemory model.
module tb_store_buffer;

    logic        clk;
    logic        Reset;
    logic        StReq;
    logic        LdReq;
    logic [15:0] CpuAdresa;
    logic [15:0] CpuWriteData;
    logic [15:0] CpuReadData;
    logic        CpuReady;
    logic        Full;
    logic        Empty;
    logic [15:0] Adresa;
    logic [15:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [15:0] ReadData;

    logic [15:0] mem [0:255];
    int          wr_cnt;
    int          checks;
    int          failures;

    store_buffer #(.DEPTH(4), .AW(16), .DW(16)) dut (
        .Clock        (clk),
        .Reset        (Reset),
        .StReq        (StReq),
        .LdReq        (LdReq),
        .CpuAdresa    (CpuAdresa),
        .CpuWriteData (CpuWriteData),
        .CpuReadData  (CpuReadData),
        .CpuReady     (CpuReady),
        .Full         (Full),
        .Empty        (Empty),
        .Adresa       (Adresa),
        .WriteData    (WriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .ReadData     (ReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ReadData = mem[Adresa[7:0]];

    always @(posedge clk) begin
        if (MemWrite) begin
            mem[Adresa[7:0]] <= WriteData;
            wr_cnt <= wr_cnt + 1;
        end
    end

    typedef struct {
        logic        st;
        logic        ld;
        logic [15:0] adr;
        logic [15:0] wd;
        logic        rdy;
        logic [15:0] rd;
        logic        mw;
        logic        mr;
        logic [15:0] madr;
        logic [15:0] mwd;
        logic        e;
        logic        f;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic ld, input logic [15:0] adr,
                                input logic [15:0] wd, input logic rdy, input logic [15:0] rd,
                                input logic mw, input logic mr, input logic [15:0] madr,
                                input logic [15:0] mwd, input logic e, input logic f);
        vec_t v;
        v.st = st;   v.ld = ld;   v.adr = adr;   v.wd = wd;
        v.rdy = rdy; v.rd = rd;   v.mw = mw;     v.mr = mr;
        v.madr = madr; v.mwd = mwd; v.e = e;     v.f = f;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        StReq        = v.st;
        LdReq        = v.ld;
        CpuAdresa    = v.adr;
        CpuWriteData = v.wd;
        #2;
        chk({tag, ".rdy"},   {15'd0, CpuReady}, {15'd0, v.rdy});
        chk({tag, ".rdata"}, CpuReadData,       v.rd);
        chk({tag, ".mw"},    {15'd0, MemWrite}, {15'd0, v.mw});
        chk({tag, ".mr"},    {15'd0, MemRead},  {15'd0, v.mr});
        chk({tag, ".madr"},  Adresa,            v.madr);
        chk({tag, ".mwd"},   WriteData,         v.mwd);
        chk({tag, ".empty"}, {15'd0, Empty},    {15'd0, v.e});
        chk({tag, ".full"},  {15'd0, Full},     {15'd0, v.f});
    endtask

    vec_t tbl [12];
    int   wr_snap;

    initial begin
        checks   = 0;
        failures = 0;
        wr_cnt   = 0;
        for (int a = 0; a < 256; a++) mem[a] = 16'hA000 | 16'(a);

        // Reset held with a store request present: nothing may be accepted.
        Reset = 1'b0; StReq = 1'b1; LdReq = 1'b0;
        CpuAdresa = 16'h0005; CpuWriteData = 16'h1234;
        @(posedge clk); @(posedge clk); #2;
        chk("rst.rdy",   {15'd0, CpuReady}, 16'd0);
        chk("rst.rdata", CpuReadData,       16'h0000);
        chk("rst.empty", {15'd0, Empty},    16'd1);
        chk("rst.full",  {15'd0, Full},     16'd0);
        chk("rst.mw",    {15'd0, MemWrite}, 16'd0);
        chk("rst.mr",    {15'd0, MemRead},  16'd0);
        chk("rst.madr",  Adresa,            16'h0000);
        chk("rst.mwd",   WriteData,         16'h0000);
        @(negedge clk);
        Reset = 1'b1; StReq = 1'b0; CpuAdresa = '0; CpuWriteData = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #2;
            chk($sformatf("idle%0d.empty", i), {15'd0, Empty},    16'd1);
            chk($sformatf("idle%0d.full", i),  {15'd0, Full},     16'd0);
            chk($sformatf("idle%0d.mw", i),    {15'd0, MemWrite}, 16'd0);
            chk($sformatf("idle%0d.mr", i),    {15'd0, MemRead},  16'd0);
        end

        // Store/drain, forwarding and simultaneous-request table.
        tbl[0]  = mk(0,0,16'h0000,16'h0000, 0,16'h0000, 0,0,16'h0000,16'h0000, 1,0);
        tbl[1]  = mk(1,0,16'h000C,16'h0007, 1,16'h0000, 0,0,16'h0000,16'h0000, 1,0);
        tbl[2]  = mk(0,0,16'h0000,16'h0000, 0,16'h0000, 1,0,16'h000C,16'h0007, 0,0);
        tbl[3]  = mk(0,1,16'h000C,16'h0000, 1,16'h0007, 0,1,16'h000C,16'h0000, 1,0);
        tbl[4]  = mk(1,0,16'h000C,16'h0011, 1,16'h0007, 0,0,16'h0000,16'h0000, 1,0);
        tbl[5]  = mk(1,0,16'h000C,16'h0022, 1,16'h0007, 1,0,16'h000C,16'h0011, 0,0);
        tbl[6]  = mk(0,1,16'h000C,16'h0000, 1,16'h0022, 1,0,16'h000C,16'h0022, 0,0);
        tbl[7]  = mk(0,1,16'h000D,16'h0000, 1,16'hA00D, 0,1,16'h000D,16'h0000, 1,0);
        tbl[8]  = mk(0,0,16'h0000,16'h0000, 0,16'hA00D, 0,0,16'h0000,16'h0000, 1,0);
        tbl[9]  = mk(1,1,16'h0020,16'h0055, 1,16'hA00D, 0,0,16'h0000,16'h0000, 1,0);
        tbl[10] = mk(0,1,16'h0020,16'h0000, 1,16'h0055, 1,0,16'h0020,16'h0055, 0,0);
        tbl[11] = mk(0,1,16'h0020,16'h0000, 1,16'h0055, 0,1,16'h0020,16'h0000, 1,0);
        for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Fill to DEPTH while a missing load blocks draining, then stall and release.
        apply(mk(1,1,16'h0041,16'h0101, 1,16'h0055, 0,0,16'h0000,16'h0000, 1,0), "full.s1");
        apply(mk(1,1,16'h0042,16'h0102, 1,16'h0055, 0,0,16'h0000,16'h0000, 0,0), "full.s2");
        apply(mk(1,1,16'h0043,16'h0103, 1,16'h0055, 0,0,16'h0000,16'h0000, 0,0), "full.s3");
        apply(mk(1,1,16'h0044,16'h0104, 1,16'h0055, 0,0,16'h0000,16'h0000, 0,0), "full.s4");
        apply(mk(1,1,16'h0045,16'h0105, 0,16'h0055, 0,0,16'h0000,16'h0000, 0,1), "full.s5stall");
        apply(mk(1,0,16'h0045,16'h0105, 1,16'h0055, 1,0,16'h0041,16'h0101, 0,1), "full.s5acc");
        apply(mk(0,0,16'h0000,16'h0000, 0,16'h0055, 1,0,16'h0042,16'h0102, 0,1), "full.d2");
        apply(mk(0,0,16'h0000,16'h0000, 0,16'h0055, 1,0,16'h0043,16'h0103, 0,0), "full.d3");
        apply(mk(0,0,16'h0000,16'h0000, 0,16'h0055, 1,0,16'h0044,16'h0104, 0,0), "full.d4");
        apply(mk(0,0,16'h0000,16'h0000, 0,16'h0055, 1,0,16'h0045,16'h0105, 0,0), "full.d5");
        apply(mk(0,1,16'h0045,16'h0000, 1,16'h0105, 0,1,16'h0045,16'h0000, 1,0), "full.ld45");
        apply(mk(0,1,16'h0041,16'h0000, 1,16'h0101, 0,1,16'h0041,16'h0000, 1,0), "full.ld41");

        // Two buffered stores to one address across the pointer wrap: youngest wins.
        apply(mk(1,1,16'h0051,16'h0002, 1,16'h0101, 0,0,16'h0000,16'h0000, 1,0), "yng.s51");
        apply(mk(1,1,16'h0050,16'h0001, 1,16'h0101, 0,0,16'h0000,16'h0000, 0,0), "yng.s50a");
        apply(mk(1,1,16'h0050,16'h0003, 1,16'h0101, 1,0,16'h0051,16'h0002, 0,0), "yng.s50b");
        apply(mk(0,1,16'h0050,16'h0000, 1,16'h0003, 1,0,16'h0050,16'h0001, 0,0), "yng.ldhit");
        apply(mk(0,0,16'h0000,16'h0000, 0,16'h0003, 1,0,16'h0050,16'h0003, 0,0), "yng.drain");
        apply(mk(0,1,16'h0050,16'h0000, 1,16'h0003, 0,1,16'h0050,16'h0000, 1,0), "yng.ldmem");

        // Reset while three stores are buffered and the first is draining.
        apply(mk(1,1,16'h0060,16'h0AAA, 1,16'h0003, 0,0,16'h0000,16'h0000, 1,0), "rmd.s60");
        apply(mk(1,1,16'h0061,16'h0BBB, 1,16'h0003, 0,0,16'h0000,16'h0000, 0,0), "rmd.s61");
        apply(mk(1,1,16'h0062,16'h0CCC, 1,16'h0003, 0,0,16'h0000,16'h0000, 0,0), "rmd.s62");
        @(negedge clk);
        StReq = 1'b0; LdReq = 1'b0; CpuAdresa = '0; CpuWriteData = '0;
        #2;
        chk("rmd.pre.mw",   {15'd0, MemWrite}, 16'd1);
        chk("rmd.pre.madr", Adresa,            16'h0060);
        wr_snap = wr_cnt;
        #1 Reset = 1'b0;
        #1;
        chk("rmd.async.mw",    {15'd0, MemWrite}, 16'd0);
        chk("rmd.async.empty", {15'd0, Empty},    16'd1);
        chk("rmd.async.madr",  Adresa,            16'h0000);
        chk("rmd.async.rdata", CpuReadData,       16'h0000);
        @(negedge clk);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #2;
            chk($sformatf("rmd.post%0d.mw", i),    {15'd0, MemWrite}, 16'd0);
            chk($sformatf("rmd.post%0d.empty", i), {15'd0, Empty},    16'd1);
        end
        chk("rmd.writes", 16'(wr_cnt - wr_snap), 16'd0);
        chk("rmd.mem60", mem[8'h60], 16'hA060);
        chk("rmd.mem61", mem[8'h61], 16'hA061);
        chk("rmd.mem62", mem[8'h62], 16'hA062);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
